// File: rtl/seg_pkg.sv
// Glyph, unit-code and anode constants for the 4-digit active-low seven-segment scanner.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // The hex 'C' glyph doubles as the Celsius letter.
  localparam logic [6:0] GLYPH_K      = 7'h0A;
  localparam logic [6:0] GLYPH_F_UNIT = 7'h0E;
  localparam logic [6:0] GLYPH_DASH   = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK  = 7'h7F;

  localparam logic [1:0] UNIT_C    = 2'b00;
  localparam logic [1:0] UNIT_K    = 2'b01;
  localparam logic [1:0] UNIT_F    = 2'b10;
  localparam logic [1:0] UNIT_NONE = 2'b11;

  // Indexed by digit number; digit 0 is the rightmost.
  localparam logic [3:0][3:0] ANODE_TABLE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

endpackage

// File: rtl/seg_glyph_decoder.sv
// Combinational code-to-segment decoder: hex digit, or unit letter when letter=1 (code[1:0] = unit).
// Zero latency; no flow control.
module seg_glyph_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       letter,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    if (letter) begin
      case (code[1:0])
        UNIT_C:  seg = GLYPH_C;
        UNIT_K:  seg = GLYPH_K;
        UNIT_F:  seg = GLYPH_F_UNIT;
        default: seg = GLYPH_DASH;
      endcase
    end else begin
      case (code)
        4'h0:    seg = GLYPH_0;
        4'h1:    seg = GLYPH_1;
        4'h2:    seg = GLYPH_2;
        4'h3:    seg = GLYPH_3;
        4'h4:    seg = GLYPH_4;
        4'h5:    seg = GLYPH_5;
        4'h6:    seg = GLYPH_6;
        4'h7:    seg = GLYPH_7;
        4'h8:    seg = GLYPH_8;
        4'h9:    seg = GLYPH_9;
        4'hA:    seg = GLYPH_A;
        4'hB:    seg = GLYPH_B;
        4'hC:    seg = GLYPH_C;
        4'hD:    seg = GLYPH_D;
        4'hE:    seg = GLYPH_E;
        default: seg = GLYPH_F;
      endcase
    end
  end

endmodule

// File: rtl/unit_seg_display.sv
// Free-running 4-digit scanner: digit 0 = hex of z, digit 3 = unit letter; inputs latched per frame.
// an/seg registered one cycle behind the digit index; no handshake, never stalls.
module unit_seg_display
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] z,
  input  logic [1:0] sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int                CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       d;
  logic [3:0]       val_q;
  logic [1:0]       sel_q;
  logic             tick;

  logic [3:0]       dec_code;
  logic             dec_letter;
  logic [6:0]       dec_seg;
  logic [6:0]       seg_next;

  assign tick = (cnt == CNT_MAX);

  // Snapshot only at the frame boundary so a frame never mixes old and new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      d     <= 2'd0;
      val_q <= 4'h0;
      sel_q <= UNIT_C;
    end else if (tick) begin
      cnt <= '0;
      d   <= d + 2'd1;
      if (d == 2'd3) begin
        val_q <= z;
        sel_q <= sel;
      end
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign dec_letter = (d == 2'd3);
  assign dec_code   = dec_letter ? {2'b00, sel_q} : val_q;

  seg_glyph_decoder u_decoder (
    .code   (dec_code),
    .letter (dec_letter),
    .seg    (dec_seg)
  );

  assign seg_next = ((d == 2'd1) || (d == 2'd2)) ? GLYPH_BLANK : dec_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'hF;
      seg <= GLYPH_BLANK;
    end else begin
      an  <= ANODE_TABLE[d];
      seg <= seg_next;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_unit_seg_display.sv
// Randomized bench for unit_seg_display against a cycle-count reference model (REFRESH_DIV=4).
module tb_unit_seg_display;

  localparam int R     = 4;
  localparam int FRAME = 4 * R;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] z;
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_vec = 0;
  int n_err = 0;

  // Model state: edges since reset release, and the snapshot the display currently shows.
  int         k = 0;
  logic [3:0] snap_z = 4'h0;
  logic [1:0] snap_sel = 2'b00;

  logic [6:0] hex_glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  unit_seg_display #(.REFRESH_DIV(R)) dut (
    .clk (clk),
    .rst (rst),
    .z   (z),
    .sel (sel),
    .an  (an),
    .seg (seg),
    .dp  (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (k=%0d, t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  function automatic logic [6:0] unit_glyph(input logic [1:0] s);
    case (s)
      2'b00:   return 7'h46;
      2'b01:   return 7'h0A;
      2'b10:   return 7'h0E;
      default: return 7'h3F;
    endcase
  endfunction

  // One clock edge: inputs present now are what the DUT samples; outputs checked 1 time unit later.
  task automatic cycle();
    logic       r;
    logic [3:0] zz;
    logic [1:0] ss;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int         dig;
    r  = rst;
    zz = z;
    ss = sel;
    @(posedge clk);
    if (r) begin
      exp_an   = 4'hF;
      exp_seg  = 7'h7F;
      k        = 0;
      snap_z   = 4'h0;
      snap_sel = 2'b00;
    end else begin
      k++;
      dig    = ((k - 1) / R) % 4;
      exp_an = ~(4'b0001 << dig);
      case (dig)
        0:       exp_seg = hex_glyph[snap_z];
        3:       exp_seg = unit_glyph(snap_sel);
        default: exp_seg = 7'h7F;
      endcase
      if (k % FRAME == 0) begin
        snap_z   = zz;
        snap_sel = ss;
      end
    end
    #1;
    check("an", an, exp_an);
    check("seg", seg, exp_seg);
    check("dp", dp, 1'b1);
    if (!r) check("an_onehot", $countones(~an), 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until the model's edge count reaches the given phase within the frame.
  task automatic run_to_phase(input int phase);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (k % FRAME == phase) return;
      cycle();
    end
    check("phase_reached", k % FRAME, phase);
  endtask

  initial begin
    rst = 1'b1;
    z   = 4'h7;
    sel = 2'b00;
    run(2);
    rst = 1'b0;
    run(2 * FRAME);

    // Change z mid-frame (digit 1 lit): digit 0 must hold the old value until the next frame.
    z = 4'h3;
    run(FRAME);
    run_to_phase(6);
    z = 4'h9;
    run(2 * FRAME);

    sel = 2'b01; z = 4'hB; run(2 * FRAME);
    sel = 2'b10; z = 4'hF; run(2 * FRAME);
    sel = 2'b11; z = 4'h0; run(2 * FRAME);

    // Reset while digit 2 is lit, after z=5 has been captured.
    sel = 2'b00; z = 4'h5; run(2 * FRAME);
    run_to_phase(10);
    rst = 1'b1; run(1);
    rst = 1'b0; run(FRAME + 4);

    // Constant input across several frames exercises the 3->0 wrap.
    sel = 2'b01; z = 4'hA; run(4 * FRAME);

    // Inputs changed exactly at a frame boundary edge are captured on that edge.
    run_to_phase(FRAME - 1);
    z = 4'hD; sel = 2'b10; run(1);
    z = 4'h2; sel = 2'b00; run(FRAME + 2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) z = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) sel = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    run(FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unit_seg_display.md
Name: unit_seg_display

Overview:
- Downstream consumer of the 4-bit temperature-unit mux output `z[3:0]` and its `sel[1:0]`.
- Drives the board's 4-digit, common-anode, active-low seven-segment display by time-multiplexed scanning.
- Digit 0 shows `z` as a hex glyph; digit 3 shows the selected unit letter (C/K/F); digits 1–2 are blank.
- Inputs are snapshotted once per scan frame so the display never tears.

Parameters:
- REFRESH_DIV, default 100000 — clk cycles each digit is lit (1 kHz per digit at 100 MHz). Legal range ≥ 2. Sim uses 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- z    in  4  value from the unit mux
- sel  in  2  unit select: 00=C, 01=K, 10=F, 11=invalid
- an   out 4  digit anodes, active-low; an[0] is the rightmost digit
- seg  out 7  segments, active-low; seg[6:0] = {g,f,e,d,c,b,a}
- dp   out 1  decimal point, active-low; always 1 (off)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst) and dominates all other logic on the same edge.

Reset values:
- an=4'hF, seg=7'h7F, dp=1.
- Internal state: prescaler cnt=0, digit index d=0, snapshots val_q=0 and sel_q=2'b00.

Prescaler:
- cnt increments every non-reset cycle.
- tick = (cnt == REFRESH_DIV-1). On tick, cnt<=0 and d<=d+1, wrapping 3→0.
- Each digit is therefore lit for exactly REFRESH_DIV cycles; one frame = 4*REFRESH_DIV cycles.

Snapshot:
- On tick with d==3 (frame boundary): val_q<=z, sel_q<=sel.
- z/sel changes at any other time have no visible effect until the next boundary.
- The first frame after reset displays val_q=0, sel_q=00 ("C" on digit 3, "0" on digit 0).

Output register:
- an/seg are registered from the current d, val_q and sel_q, so they reflect the new digit one cycle after d changes.
- an is one-hot-low: d0→1110, d1→1101, d2→1011, d3→0111. Exactly one digit is enabled after the first post-reset cycle.

Glyphs (seg hex values):
- Digits 0–F: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.
- Digit 0 shows glyph(val_q).
- Digits 1 and 2 show blank (7F).
- Digit 3 shows the unit letter: C=46, K=0A (a,c,e,f,g lit), F=0E. sel_q=11 shows dash 3F.

Boundary conditions:
- Reset mid-frame: scan restarts at d0 with zeroed snapshots on the next edge.
- z/sel change on the same edge as the d==3 tick: the value sampled on that edge is captured.
- No other modes and no handshake; the block free-runs.

Decomposition:
- Package seg_pkg holds:
  - active-low glyph constants (GLYPH_0..GLYPH_F, GLYPH_C, GLYPH_K, GLYPH_F_UNIT, GLYPH_DASH, GLYPH_BLANK);
  - unit encoding constants UNIT_C=2'b00, UNIT_K=2'b01, UNIT_F=2'b10, UNIT_NONE=2'b11;
  - the anode one-hot table.
- One combinational sub-module, seg_glyph_decoder: inputs are a 4-bit code and a letter-mode flag; output is seg[6:0].
- Prescaler, scan counter, snapshot and output registers stay in the top module.

Test Plan (REFRESH_DIV=4):
- Reset: rst high 2 cycles → an=F, seg=7F, dp=1. First cycle after release → an=1110, seg=40.
- Scan timing: z=7, sel=00 from reset. Cycles 1–16 show the "C…0" frame with an sequence 1110/1101/1011/0111, each held 4 cycles. From cycle 17: digit 0 seg=78, digit 3 seg=46, digits 1–2 seg=7F.
- No tearing: after a frame with z=3, change z to 9 while d=1 → digit 0 stays 30 for the rest of the frame and becomes 10 only in the next frame.
- Units: sel=01, z=B → digit 3 0A, digit 0 03. sel=10, z=F → both 0E. sel=11, z=0 → digit 3 3F, digit 0 40.
- Mid-frame reset: assert rst while d=2 with z=5 captured → next cycle an=F, seg=7F. After release, scan restarts at an=1110 showing 40 (snapshot cleared).
- Wrap-around: run 3 full frames with a constant input → every frame shows an identical 16-cycle an/seg pattern; dp stays 1 throughout.
